spi_master_param: RTL

Parametrised SPI master, successor to the fixed 8-bit mode-0 controller. Adds configurable word width, SCLK divider, all four CPOL/CPHA modes, multiple chip selects and a receive handshake with overrun flag. Sits between a local strobe/ack bus and one SPI bus with up to NUM_CS slaves. All logic runs on one system clock; SCLK is derived internally, not used as a clock.

---
 rtl/spi_master_param.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/spi_master_param.sv
// Parametrised SPI master: DATA_W-bit words, CLK_DIV SCLK divider, all CPOL/CPHA modes, NUM_CS selects.
// Define LSB_FIRST_EN to add the LSB_FIRST input (per-transfer LSB-first shifting).
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_CS  = 2,
  parameter int CS_W    = 1
) (
  input  logic              IN_SCLK,
  input  logic              RST,
  input  logic              W_STB,
  input  logic [DATA_W-1:0] W_DATA,
  input  logic [1:0]        MODE,
  input  logic [CS_W-1:0]   CS_SEL,
`ifdef LSB_FIRST_EN
  input  logic              LSB_FIRST,
`endif
  output logic              W_ACK,
  output logic [DATA_W-1:0] R_DATA,
  output logic              R_STB,
  input  logic              R_ACK,
  output logic              OVR,
  output logic              BUSY,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_CS-1:0] CS_N
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_END  = EDGE_W'(2 * DATA_W);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   r_data_q, r_data_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic [1:0]          mode_q, mode_d;
  logic                lsb_q, lsb_d;
  logic                mosi_q, mosi_d;
  logic                sclk_q, sclk_d;
  logic                w_ack_q, w_ack_d;
  logic                r_stb_q, r_stb_d;
  logic                ovr_q, ovr_d;

  logic                lsb_in;
  logic                tick;
  logic                do_edge;
  logic                leading;
  logic                done;

`ifdef LSB_FIRST_EN
  assign lsb_in = LSB_FIRST;
`else
  assign lsb_in = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    r_data_d   = r_data_q;
    cs_n_d     = cs_n_q;
    mode_d     = mode_q;
    lsb_d      = lsb_q;
    mosi_d     = mosi_q;
    sclk_d     = sclk_q;
    w_ack_d    = 1'b0;
    r_stb_d    = r_stb_q;
    ovr_d      = ovr_q;
    do_edge    = 1'b0;
    done       = 1'b0;
    leading    = ~edge_cnt_q[0];
    tick       = (div_cnt_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        if (W_STB) begin
          state_d    = SETUP;
          w_ack_d    = 1'b1;
          tx_d       = W_DATA;
          rx_d       = '0;
          mode_d     = MODE;
          lsb_d      = lsb_in;
          sclk_d     = MODE[1];
          mosi_d     = lsb_in ? W_DATA[0] : W_DATA[DATA_W-1];
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          for (int i = 0; i < NUM_CS; i++) cs_n_d[i] = (CS_SEL != CS_W'(i));
        end
      end
      SETUP: begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        if (tick) begin
          state_d = SHIFT;
          do_edge = 1'b1;
        end
      end
      SHIFT: begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        if (tick) begin
          if (edge_cnt_q == EDGE_END) begin
            state_d = HOLD;
            done    = 1'b1;
          end else begin
            do_edge = 1'b1;
          end
        end
      end
      HOLD: begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        sclk_d    = mode_q[1];
        if (tick) begin
          state_d = IDLE;
          cs_n_d  = '1;
          mosi_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Even edge counts are leading SCLK edges; CPHA picks which edge samples and which drives.
    if (do_edge) begin
      sclk_d     = ~sclk_q;
      edge_cnt_d = edge_cnt_q + EDGE_W'(1);
      if (leading != mode_q[0])
        rx_d = lsb_q ? {MISO, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], MISO};
      if (mode_q[0] ? (leading && edge_cnt_q != '0) : (!leading && edge_cnt_q != EDGE_LAST)) begin
        tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
        mosi_d = lsb_q ? tx_q[1] : tx_q[DATA_W-2];
      end
    end

    // A completing word wins over a same-cycle acknowledge, leaving OVR untouched.
    if (done) begin
      r_data_d = rx_q;
      r_stb_d  = 1'b1;
      if (r_stb_q && !R_ACK) ovr_d = 1'b1;
    end else if (R_ACK && r_stb_q) begin
      r_stb_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge IN_SCLK) begin
    if (RST) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      r_data_q   <= '0;
      cs_n_q     <= '1;
      mode_q     <= 2'b00;
      lsb_q      <= 1'b0;
      mosi_q     <= 1'b1;
      sclk_q     <= 1'b0;
      w_ack_q    <= 1'b0;
      r_stb_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      r_data_q   <= r_data_d;
      cs_n_q     <= cs_n_d;
      mode_q     <= mode_d;
      lsb_q      <= lsb_d;
      mosi_q     <= mosi_d;
      sclk_q     <= sclk_d;
      w_ack_q    <= w_ack_d;
      r_stb_q    <= r_stb_d;
      ovr_q      <= ovr_d;
    end
  end

  assign W_ACK  = w_ack_q;
  assign R_DATA = r_data_q;
  assign R_STB  = r_stb_q;
  assign OVR    = ovr_q;
  assign BUSY   = (state_q != IDLE);
  assign SCLK   = sclk_q;
  assign MOSI   = mosi_q;
  assign CS_N   = cs_n_q;

endmodule
